// File: rtl/wb_port_arbiter.sv
// wb_port_arbiter: shares one register-file write port between two writeback
// requesters (0 = ALU result, 1 = load data). Each requester has a 1-entry
// holding buffer. A round-robin arbiter picks a buffer and its entry is
// registered onto the write port through a 2:1 data mux.
//
// Ports:
//   clk, reset_n            clock (rising edge), async active-low reset
//   req_valid[1:0]          requester i presents a write
//   req_ready[1:0]          requester i's buffer can accept this cycle
//   req_addr0/1, req_data0/1  destination register and data per requester
//   wr_en, wr_addr, wr_data, wr_src   registered register-file write port
//   busy                    at least one buffer holds an entry
//   conflict_cnt, drop_cnt  only with WB_ARB_STATS_EN: saturating counts of
//                           both-buffers-valid cycles and discarded ZERO_REG writes
//
// Optional feature macro: WB_ARB_STATS_EN
module wb_port_arbiter #(
   parameter int DATA_W   = 64,
   parameter int ADDR_W   = 5,
   parameter int ZERO_REG = 31
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic [1:0]        req_valid,
   output logic [1:0]        req_ready,
   input  logic [ADDR_W-1:0] req_addr0,
   input  logic [DATA_W-1:0] req_data0,
   input  logic [ADDR_W-1:0] req_addr1,
   input  logic [DATA_W-1:0] req_data1,
   output logic              wr_en,
   output logic [ADDR_W-1:0] wr_addr,
   output logic [DATA_W-1:0] wr_data,
   output logic              wr_src,
`ifdef WB_ARB_STATS_EN
   output logic [15:0]       conflict_cnt,
   output logic [15:0]       drop_cnt,
`endif
   output logic              busy
);

   localparam logic [ADDR_W-1:0] ZERO_ADDR = ADDR_W'(ZERO_REG);

   logic [1:0]        buf_valid_q, buf_valid_d;
   logic [ADDR_W-1:0] buf_addr0_q, buf_addr0_d;
   logic [ADDR_W-1:0] buf_addr1_q, buf_addr1_d;
   logic [DATA_W-1:0] buf_data0_q, buf_data0_d;
   logic [DATA_W-1:0] buf_data1_q, buf_data1_d;
   logic              rr_ptr_q, rr_ptr_d;
   logic              wr_en_q, wr_en_d;
   logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
   logic [DATA_W-1:0] wr_data_q, wr_data_d;
   logic              wr_src_q, wr_src_d;
`ifdef WB_ARB_STATS_EN
   logic [15:0]       conflict_cnt_q, conflict_cnt_d;
   logic [15:0]       drop_cnt_q, drop_cnt_d;
`endif

   logic [1:0]        grant;
   logic              grant_any;
   logic              grant_idx;
   logic [DATA_W-1:0] mux_data;
   logic [ADDR_W-1:0] mux_addr;
   logic              mux_is_zero;
   logic [1:0]        accept;

   always_comb begin
      grant = 2'b00;
      case (buf_valid_q)
         2'b01:   grant = 2'b01;
         2'b10:   grant = 2'b10;
         2'b11:   grant = rr_ptr_q ? 2'b10 : 2'b01;
         default: grant = 2'b00;
      endcase
      grant_any   = |grant;
      grant_idx   = grant[1];
      mux_data    = grant_idx ? buf_data1_q : buf_data0_q;
      mux_addr    = grant_idx ? buf_addr1_q : buf_addr0_q;
      mux_is_zero = (mux_addr == ZERO_ADDR);

      // A buffer being drained this cycle can take a new entry on the same edge.
      req_ready = ~buf_valid_q | grant;
      accept    = req_valid & req_ready;

      buf_valid_d = (buf_valid_q & ~grant) | accept;
      buf_addr0_d = accept[0] ? req_addr0 : buf_addr0_q;
      buf_data0_d = accept[0] ? req_data0 : buf_data0_q;
      buf_addr1_d = accept[1] ? req_addr1 : buf_addr1_q;
      buf_data1_d = accept[1] ? req_data1 : buf_data1_q;

      rr_ptr_d  = grant_any ? ~grant_idx : rr_ptr_q;

      // ZERO_REG entries are drained but never reach the register file.
      wr_en_d   = grant_any & ~mux_is_zero;
      wr_addr_d = grant_any ? mux_addr  : wr_addr_q;
      wr_data_d = grant_any ? mux_data  : wr_data_q;
      wr_src_d  = grant_any ? grant_idx : wr_src_q;

`ifdef WB_ARB_STATS_EN
      conflict_cnt_d = conflict_cnt_q;
      if ((&buf_valid_q) && (conflict_cnt_q != 16'hFFFF))
         conflict_cnt_d = conflict_cnt_q + 16'd1;
      drop_cnt_d = drop_cnt_q;
      if (grant_any && mux_is_zero && (drop_cnt_q != 16'hFFFF))
         drop_cnt_d = drop_cnt_q + 16'd1;
`endif
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         buf_valid_q    <= '0;
         buf_addr0_q    <= '0;
         buf_data0_q    <= '0;
         buf_addr1_q    <= '0;
         buf_data1_q    <= '0;
         rr_ptr_q       <= 1'b0;
         wr_en_q        <= 1'b0;
         wr_addr_q      <= '0;
         wr_data_q      <= '0;
         wr_src_q       <= 1'b0;
`ifdef WB_ARB_STATS_EN
         conflict_cnt_q <= '0;
         drop_cnt_q     <= '0;
`endif
      end else begin
         buf_valid_q    <= buf_valid_d;
         buf_addr0_q    <= buf_addr0_d;
         buf_data0_q    <= buf_data0_d;
         buf_addr1_q    <= buf_addr1_d;
         buf_data1_q    <= buf_data1_d;
         rr_ptr_q       <= rr_ptr_d;
         wr_en_q        <= wr_en_d;
         wr_addr_q      <= wr_addr_d;
         wr_data_q      <= wr_data_d;
         wr_src_q       <= wr_src_d;
`ifdef WB_ARB_STATS_EN
         conflict_cnt_q <= conflict_cnt_d;
         drop_cnt_q     <= drop_cnt_d;
`endif
      end
   end

   assign wr_en   = wr_en_q;
   assign wr_addr = wr_addr_q;
   assign wr_data = wr_data_q;
   assign wr_src  = wr_src_q;
   assign busy    = |buf_valid_q;
`ifdef WB_ARB_STATS_EN
   assign conflict_cnt = conflict_cnt_q;
   assign drop_cnt     = drop_cnt_q;
`endif

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Bench for wb_port_arbiter. A transaction-level reference model (one pending
// queue per requester plus a "who waits goes next" priority) predicts each
// register-file write and the cycle it must appear; a separate monitor pops
// and compares whenever the DUT raises wr_en.
module tb_wb_port_arbiter;

   typedef struct {
      logic [4:0]  addr;
      logic [63:0] data;
   } ent_t;

   typedef struct {
      logic [4:0]  addr;
      logic [63:0] data;
      logic        src;
      int          cyc;
   } wr_t;

   logic        clk;
   logic        reset_n;
   logic [1:0]  req_valid;
   logic [1:0]  req_ready;
   logic [4:0]  req_addr0, req_addr1;
   logic [63:0] req_data0, req_data1;
   logic        wr_en;
   logic [4:0]  wr_addr;
   logic [63:0] wr_data;
   logic        wr_src;
   logic        busy;
`ifdef WB_ARB_STATS_EN
   logic [15:0] conflict_cnt;
   logic [15:0] drop_cnt;
`endif

   int n_assert = 0;
   int n_fail   = 0;
   int cyc      = 0;
   int drops    = 0;
   int prio     = 0;
   ent_t pend0[$];
   ent_t pend1[$];
   wr_t  exp_q[$];

   wb_port_arbiter dut (
      .clk          (clk),
      .reset_n      (reset_n),
      .req_valid    (req_valid),
      .req_ready    (req_ready),
      .req_addr0    (req_addr0),
      .req_data0    (req_data0),
      .req_addr1    (req_addr1),
      .req_data1    (req_data1),
      .wr_en        (wr_en),
      .wr_addr      (wr_addr),
      .wr_data      (wr_data),
      .wr_src       (wr_src),
`ifdef WB_ARB_STATS_EN
      .conflict_cnt (conflict_cnt),
      .drop_cnt     (drop_cnt),
`endif
      .busy         (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_assert++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Who gets the port this cycle: a lone waiter, or on contention the one
   // whose turn it is.
   function automatic int model_grant();
      bit has0 = pend0.size() > 0;
      bit has1 = pend1.size() > 0;
      if (has0 && has1) return prio;
      if (has0) return 0;
      if (has1) return 1;
      return -1;
   endfunction

   task automatic step(input logic [1:0] v, input logic [4:0] a0, input logic [63:0] d0,
                       input logic [4:0] a1, input logic [63:0] d1);
      int   g;
      logic [1:0] rdy;
      ent_t e;
      wr_t  w;
      @(negedge clk);
      g = model_grant();
      rdy[0] = (pend0.size() == 0) || (g == 0);
      rdy[1] = (pend1.size() == 0) || (g == 1);
      chk("req_ready", {62'd0, req_ready}, {62'd0, rdy});
      chk("busy", {63'd0, busy}, {63'd0, (pend0.size() + pend1.size()) > 0});
      req_valid = v;
      req_addr0 = a0;
      req_data0 = d0;
      req_addr1 = a1;
      req_data1 = d1;
      @(posedge clk);
      cyc++;
      if (g >= 0) begin
         e = (g == 0) ? pend0.pop_front() : pend1.pop_front();
         if (e.addr == 5'd31) drops++;
         else begin
            w.addr = e.addr;
            w.data = e.data;
            w.src  = g[0];
            w.cyc  = cyc;
            exp_q.push_back(w);
         end
         prio = 1 - g;
      end
      if (v[0] && rdy[0]) begin e.addr = a0; e.data = d0; pend0.push_back(e); end
      if (v[1] && rdy[1]) begin e.addr = a1; e.data = d1; pend1.push_back(e); end
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(2'b00, 5'd0, 64'd0, 5'd0, 64'd0);
   endtask

   always @(negedge clk) begin
      wr_t w;
      if (reset_n && wr_en) begin
         if (exp_q.size() == 0) begin
            chk("unexpected_write", {59'd0, wr_addr}, 64'hFFFF_FFFF_FFFF_FFFF);
         end else begin
            w = exp_q.pop_front();
            chk("wr_addr", {59'd0, wr_addr}, {59'd0, w.addr});
            chk("wr_data", wr_data, w.data);
            chk("wr_src",  {63'd0, wr_src}, {63'd0, w.src});
            chk("wr_cycle", 64'(cyc), 64'(w.cyc));
         end
      end
   end

   initial begin
      reset_n   = 1'b0;
      req_valid = 2'b00;
      req_addr0 = '0; req_data0 = '0;
      req_addr1 = '0; req_data1 = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      reset_n = 1'b1;
      chk("rst_wr_en",   {63'd0, wr_en}, 64'd0);
      chk("rst_wr_addr", {59'd0, wr_addr}, 64'd0);
      chk("rst_wr_data", wr_data, 64'd0);
      chk("rst_wr_src",  {63'd0, wr_src}, 64'd0);
      chk("rst_busy",    {63'd0, busy}, 64'd0);
      chk("rst_ready",   {62'd0, req_ready}, 64'd3);
      idle(2);

      // single request
      step(2'b01, 5'd3, 64'h1F, 5'd0, 64'd0);
      idle(3);

      // mid-stream reset drops buffered entries
      step(2'b11, 5'd7, 64'hAA, 5'd8, 64'hBB);
      step(2'b11, 5'd9, 64'hCC, 5'd10, 64'hDD);
      @(negedge clk);
      reset_n   = 1'b0;
      req_valid = 2'b00;
      #1;
      chk("midrst_wr_en", {63'd0, wr_en}, 64'd0);
      chk("midrst_busy",  {63'd0, busy}, 64'd0);
      pend0.delete();
      pend1.delete();
      exp_q.delete();
      prio = 0;
      @(negedge clk);
      reset_n = 1'b1;
      idle(1);

      // conflict with pointer at 0, then a lone req0, then conflict again
      step(2'b11, 5'd4, 64'hA, 5'd5, 64'hB);
      idle(3);
      step(2'b01, 5'd6, 64'h66, 5'd0, 64'd0);
      idle(3);
      step(2'b11, 5'd4, 64'hA2, 5'd5, 64'hB2);
      idle(3);

      // continuous req1 traffic
      for (int i = 0; i < 8; i++) step(2'b10, 5'd0, 64'd0, 5'd12, 64'h100 + 64'(i));
      idle(3);

      // discarded ZERO_REG write
      step(2'b01, 5'd31, 64'hDEAD, 5'd0, 64'd0);
      idle(3);

      // random traffic
      for (int i = 0; i < 600; i++) begin
         logic [1:0]  v;
         logic [4:0]  a0, a1;
         logic [63:0] d0, d1;
         v  = 2'($urandom_range(3, 0));
         a0 = 5'($urandom_range(31, 0));
         a1 = 5'($urandom_range(31, 0));
         d0 = {$urandom(), $urandom()};
         d1 = {$urandom(), $urandom()};
         step(v, a0, d0, a1, d1);
      end
      idle(4);
      chk("exp_q_drained", 64'(exp_q.size()), 64'd0);

`ifdef WB_ARB_STATS_EN
      chk("drop_cnt", {48'd0, drop_cnt}, 64'(drops));
      for (int i = 0; i < 70000; i++) step(2'b11, 5'd1, 64'(i), 5'd2, 64'(i));
      idle(3);
      chk("conflict_cnt_sat", {48'd0, conflict_cnt}, 64'hFFFF);
      chk("exp_q_drained_stats", 64'(exp_q.size()), 64'd0);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
